// File: rtl/single_in_to_x_out.sv
// Serial-to-parallel deserializer: gathers a qualified 1-bit stream into NUM_OUTS-bit
// words and hands each finished word out through a one-deep valid/ready register.
module single_in_to_x_out #(
  parameter int NUM_OUTS  = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in,
  input  logic                in_valid,
  input  logic                sync,
  output logic [NUM_OUTS-1:0] out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  output logic                misalign
);

  localparam int IDX_W = $clog2(NUM_OUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTS - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  // Map the arrival index of a bit to its position in the assembled word.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx);
    if (LSB_FIRST != 0) bit_pos = idx;
    else                bit_pos = LAST_IDX - idx;
  endfunction

  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0]    eff_idx, pos;
  logic [NUM_OUTS-1:0] shift_q, shift_d;
  logic [NUM_OUTS-1:0] out_q, out_d;
  state_t              state_q, state_d;
  logic                overrun_q, overrun_d;
  logic                misalign_q, misalign_d;
  logic                word_done;

  // Stage p0: bit capture and word-index tracking
  always_comb begin
    eff_idx    = sync ? '0 : bit_idx_q;
    pos        = bit_pos(eff_idx);
    shift_d    = shift_q;
    if (in_valid) shift_d[pos] = in;
    // A sync bit always restarts at index 0, so with NUM_OUTS >= 2 it can never finish a word.
    word_done  = in_valid && !sync && (bit_idx_q == LAST_IDX);
    bit_idx_d  = bit_idx_q;
    if (sync)
      bit_idx_d = in_valid ? IDX_W'(1) : '0;
    else if (in_valid)
      bit_idx_d = (bit_idx_q == LAST_IDX) ? '0 : bit_idx_q + IDX_W'(1);
    misalign_d = misalign_q | (sync && (bit_idx_q != '0));
  end

  // Stage p1: one-deep output register and its handshake state
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    overrun_d = overrun_q;
    if (word_done) out_d = shift_d;
    case (state_q)
      EMPTY: if (word_done) state_d = FULL;
      FULL: begin
        if (word_done) begin
          state_d = FULL;
          if (!out_ready) overrun_d = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx_q  <= '0;
      shift_q    <= '0;
      out_q      <= '0;
      state_q    <= EMPTY;
      overrun_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      out_q      <= out_d;
      state_q    <= state_d;
      overrun_q  <= overrun_d;
      misalign_q <= misalign_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == FULL);
  assign overrun   = overrun_q;
  assign misalign  = misalign_q;

endmodule
